// File: rtl/hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_stall_unit
// Description : Pipeline stall controller for the 5-stage core. It handles
//               the hazards that operand forwarding cannot resolve:
//               - load-use: one bubble inserted between ID and EX
//               - multi-cycle data-memory access: whole-pipeline freeze until
//                 the memory acknowledges, guarded by a timeout watchdog that
//                 drops the unit into a sticky FAULT state.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   MEM_TIMEOUT : last wait-counter value tolerated in MEM_WAIT before FAULT
//   CNT_W       : wait-counter width, 2**CNT_W must exceed MEM_TIMEOUT
// Ports
//   clk_i         in   core clock, rising edge
//   rst_i         in   synchronous reset, active low
//   RS1addr_i     in   ID-stage rs1 address
//   RS2addr_i     in   ID-stage rs2 address
//   UseRS1_i      in   ID instruction reads rs1
//   UseRS2_i      in   ID instruction reads rs2
//   RDaddrE_i     in   EX-stage destination register
//   MemReadE_i    in   EX-stage instruction is a load
//   MemReqM_i     in   MEM-stage data-memory request
//   MemAckM_i     in   data-memory completion
//   PCWrite_o     out  PC update enable
//   IFIDWrite_o   out  IF/ID write enable
//   NoOp_o        out  zero ID/EX control fields (bubble)
//   StallAll_o    out  hold ID/EX, EX/MEM and MEM/WB
//   Fault_o       out  sticky memory-timeout fault
//   StallCycles_o out  stall-cycle counter (HAZARD_PERF_CNT_EN)
//   LoadUseCnt_o  out  load-use bubble counter (HAZARD_PERF_CNT_EN)
// Configuration
//   HAZARD_PERF_CNT_EN : when defined, builds the two 32-bit performance
//                        counters; otherwise both ports are tied to zero.
// ============================================================================
module hazard_stall_unit #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [4:0]  RS1addr_i,
  input  logic [4:0]  RS2addr_i,
  input  logic        UseRS1_i,
  input  logic        UseRS2_i,
  input  logic [4:0]  RDaddrE_i,
  input  logic        MemReadE_i,
  input  logic        MemReqM_i,
  input  logic        MemAckM_i,
  output logic        PCWrite_o,
  output logic        IFIDWrite_o,
  output logic        NoOp_o,
  output logic        StallAll_o,
  output logic        Fault_o,
  output logic [31:0] StallCycles_o,
  output logic [31:0] LoadUseCnt_o
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FAULT    = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(MEM_TIMEOUT);

  state_t             state;
  logic [CNT_W-1:0]   wcnt;
  logic               lu;
  logic               mw;

  // x0 is never a real producer, so a load targeting it cannot create a hazard.
  assign lu = MemReadE_i && (RDaddrE_i != 5'd0) &&
              ((UseRS1_i && (RDaddrE_i == RS1addr_i)) ||
               (UseRS2_i && (RDaddrE_i == RS2addr_i)));
  assign mw = MemReqM_i && !MemAckM_i;

  // --------------------------------------------------------------------------
  // State and wait counter
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state <= RUN;
      wcnt  <= '0;
    end else begin
      case (state)
        RUN: begin
          if (mw) begin
            state <= MEM_WAIT;
            wcnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        MEM_WAIT: begin
          // A late ack on the timeout cycle still counts as a completion.
          if (MemAckM_i) begin
            state <= RUN;
            wcnt  <= '0;
          end else if (wcnt == TIMEOUT_C) begin
            state <= FAULT;
          end else begin
            wcnt <= wcnt + 1'b1;
          end
        end
        FAULT: begin
          state <= FAULT;
        end
        default: begin
          state <= RUN;
          wcnt  <= '0;
        end
      endcase
    end
  end

  // --------------------------------------------------------------------------
  // Stall outputs: freeze outranks bubble; the bubble for an LU that arrived
  // together with a memory wait is inserted on the release cycle because the
  // ID/EX contents were held throughout the freeze.
  // --------------------------------------------------------------------------
  always_comb begin
    PCWrite_o   = 1'b0;
    IFIDWrite_o = 1'b0;
    NoOp_o      = 1'b0;
    StallAll_o  = 1'b0;
    if (rst_i) begin
      case (state)
        RUN: begin
          if (mw) begin
            StallAll_o = 1'b1;
          end else if (lu) begin
            NoOp_o = 1'b1;
          end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
          end
        end
        MEM_WAIT: begin
          if (!MemAckM_i) begin
            StallAll_o = 1'b1;
          end else if (lu) begin
            NoOp_o = 1'b1;
          end else begin
            PCWrite_o   = 1'b1;
            IFIDWrite_o = 1'b1;
          end
        end
        FAULT: begin
          StallAll_o = 1'b1;
        end
        default: begin
          StallAll_o = 1'b1;
        end
      endcase
    end
  end

  assign Fault_o = rst_i && (state == FAULT);

  // --------------------------------------------------------------------------
  // Optional performance counters
  // --------------------------------------------------------------------------
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] stall_cycles;
  logic [31:0] lu_cnt;

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      stall_cycles <= '0;
      lu_cnt       <= '0;
    end else begin
      if (!PCWrite_o) stall_cycles <= stall_cycles + 32'd1;
      if (NoOp_o)     lu_cnt       <= lu_cnt + 32'd1;
    end
  end

  assign StallCycles_o = stall_cycles;
  assign LoadUseCnt_o  = lu_cnt;
`else
  assign StallCycles_o = 32'd0;
  assign LoadUseCnt_o  = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_stall_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_stall_unit
// Description : Self-checking bench for hazard_stall_unit. A driver applies
//               one input vector per cycle and pushes the reference model's
//               expected outputs into a queue; a monitor pops and compares
//               them against the DUT in the same cycle, away from the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hazard_stall_unit;

  localparam int MEM_TIMEOUT = 15;
  localparam int CNT_W       = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic [4:0]  RS1addr_i, RS2addr_i, RDaddrE_i;
  logic        UseRS1_i, UseRS2_i, MemReadE_i, MemReqM_i, MemAckM_i;
  logic        PCWrite_o, IFIDWrite_o, NoOp_o, StallAll_o, Fault_o;
  logic [31:0] StallCycles_o, LoadUseCnt_o;

  always #5 clk = ~clk;

  hazard_stall_unit #(.MEM_TIMEOUT(MEM_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .RS1addr_i    (RS1addr_i),
    .RS2addr_i    (RS2addr_i),
    .UseRS1_i     (UseRS1_i),
    .UseRS2_i     (UseRS2_i),
    .RDaddrE_i    (RDaddrE_i),
    .MemReadE_i   (MemReadE_i),
    .MemReqM_i    (MemReqM_i),
    .MemAckM_i    (MemAckM_i),
    .PCWrite_o    (PCWrite_o),
    .IFIDWrite_o  (IFIDWrite_o),
    .NoOp_o       (NoOp_o),
    .StallAll_o   (StallAll_o),
    .Fault_o      (Fault_o),
    .StallCycles_o(StallCycles_o),
    .LoadUseCnt_o (LoadUseCnt_o)
  );

  typedef struct packed {
    logic        pcw;
    logic        ifid;
    logic        noop;
    logic        stall;
    logic        fault;
    logic [31:0] sc;
    logic [31:0] lc;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   perf_en;

  // Reference model state: 0=RUN 1=MEM_WAIT 2=FAULT
  int          m_state = 0;
  int          m_wcnt  = 0;
  logic [31:0] m_sc    = 0;
  logic [31:0] m_lc    = 0;

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs (at negedge) and push the model's expectation.
  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rde,
                     input logic mre, input logic req, input logic ack);
    exp_t e;
    logic lu, mw;
    @(negedge clk);
    rst_i = r; RS1addr_i = rs1; RS2addr_i = rs2; UseRS1_i = u1; UseRS2_i = u2;
    RDaddrE_i = rde; MemReadE_i = mre; MemReqM_i = req; MemAckM_i = ack;
    lu = mre && (rde != 0) && ((u1 && rde == rs1) || (u2 && rde == rs2));
    mw = req && !ack;
    e = '0;
    e.sc = perf_en ? m_sc : 32'd0;
    e.lc = perf_en ? m_lc : 32'd0;
    if (!r) begin
      m_state = 0; m_wcnt = 0; m_sc = 0; m_lc = 0;
    end else begin
      if (m_state == 2) begin
        e.stall = 1; e.fault = 1;
      end else if ((m_state == 0 && mw) || (m_state == 1 && !ack)) begin
        e.stall = 1;
      end else if (lu) begin
        e.noop = 1;
      end else begin
        e.pcw = 1; e.ifid = 1;
      end
      if (!e.pcw) m_sc = m_sc + 1;
      if (e.noop) m_lc = m_lc + 1;
      if (m_state == 0 && mw) begin
        m_state = 1; m_wcnt = 1;
      end else if (m_state == 1) begin
        if (ack) begin
          m_state = 0; m_wcnt = 0;
        end else if (m_wcnt == MEM_TIMEOUT) begin
          m_state = 2;
        end else begin
          m_wcnt = m_wcnt + 1;
        end
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
  endtask

  task automatic rand_cyc(input logic r);
    cyc(r, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom),
        1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
        1'($urandom), 1'($urandom));
  endtask

  // Monitor: compare combinational outputs mid-cycle, before the next edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check_val("PCWrite",    {31'd0, PCWrite_o},   {31'd0, e.pcw});
        check_val("IFIDWrite",  {31'd0, IFIDWrite_o}, {31'd0, e.ifid});
        check_val("NoOp",       {31'd0, NoOp_o},      {31'd0, e.noop});
        check_val("StallAll",   {31'd0, StallAll_o},  {31'd0, e.stall});
        check_val("Fault",      {31'd0, Fault_o},     {31'd0, e.fault});
        check_val("StallCycles", StallCycles_o,       e.sc);
        check_val("LoadUseCnt",  LoadUseCnt_o,        e.lc);
      end
    end
  end

  initial begin
`ifdef HAZARD_PERF_CNT_EN
    perf_en = 1'b1;
`else
    perf_en = 1'b0;
`endif
    rst_i = 0; RS1addr_i = 0; RS2addr_i = 0; UseRS1_i = 0; UseRS2_i = 0;
    RDaddrE_i = 0; MemReadE_i = 0; MemReqM_i = 0; MemAckM_i = 0;

    // Reset with random inputs, then hazard-free flow
    rand_cyc(0); rand_cyc(0);
    idle(2);

    // Load-use on rs2, then the same with rd=x0 and with rs2 unused
    cyc(1, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0);
    idle(1);
    cyc(1, 5'd0, 5'd0, 1, 1, 5'd0, 1, 0, 0);
    cyc(1, 5'd1, 5'd5, 1, 0, 5'd5, 1, 0, 0);
    cyc(1, 5'd7, 5'd2, 1, 0, 5'd7, 1, 0, 0);   // load-use on rs1
    idle(1);

    // 3-cycle memory wait, then a zero-wait access
    for (int i = 0; i < 3; i++) cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0);
    cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 1);
    cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 1);
    idle(1);

    // Simultaneous LU and MW: 2 freeze cycles, bubble on ack cycle
    for (int i = 0; i < 2; i++) cyc(1, 5'd1, 5'd9, 1, 1, 5'd9, 1, 1, 0);
    cyc(1, 5'd1, 5'd9, 1, 1, 5'd9, 1, 1, 1);
    idle(2);

    // Timeout: 16 freeze cycles then sticky fault; reset clears it
    for (int i = 0; i < 20; i++) cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0);
    idle(2);
    cyc(0, 5'd1, 5'd2, 1, 1, 5'd3, 0, 0, 0);
    idle(2);

    // Ack on the 16th freeze cycle: completion, no fault
    for (int i = 0; i < 15; i++) cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0);
    cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 1);
    idle(2);

    // Counter scenario from a clean reset: one bubble plus a 3-cycle wait
    cyc(0, 5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0);
    cyc(1, 5'd1, 5'd5, 1, 1, 5'd5, 1, 0, 0);
    idle(1);
    for (int i = 0; i < 3; i++) cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 0);
    cyc(1, 5'd1, 5'd2, 1, 1, 5'd3, 0, 1, 1);
    idle(1);
    @(negedge clk);
    #3;
    check_val("perf_stall_total", StallCycles_o, perf_en ? 32'd4 : 32'd0);
    check_val("perf_lu_total",    LoadUseCnt_o,  perf_en ? 32'd1 : 32'd0);

    // Random traffic with occasional resets
    for (int i = 0; i < 400; i++) rand_cyc(($urandom_range(0, 49) != 0) ? 1'b1 : 1'b0);

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
    #4;
    check_val("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
